// File: rtl/ula_exec.sv
// Registered ALU execution stage with NZCV flags and valid/ready handshakes.
// Conditional execution is compiled in when ULA_EXEC_COND_EN is defined.
module ula_exec #(
  parameter int unsigned ULA_BITS = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [ULA_BITS-1:0] a,
  input  logic [ULA_BITS-1:0] b,
  input  logic [1:0]          ALUControl,
  input  logic [2:0]          cond,
  input  logic                flags_clr,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [ULA_BITS-1:0] result,
  output logic                zero,
  output logic                carry,
  output logic                overflow,
  output logic                negative,
  output logic                executed
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_AND = 2'b10;

  logic [1:0]          r_state;
  logic [ULA_BITS-1:0] r_a;
  logic [ULA_BITS-1:0] r_b;
  logic [1:0]          r_op;
  logic [ULA_BITS-1:0] r_result;
  logic                r_z;
  logic                r_c;
  logic                r_v;
  logic                r_n;
  logic                r_executed;

  logic [ULA_BITS-1:0] w_b_eff;
  logic [ULA_BITS:0]   w_sum;
  logic [ULA_BITS-1:0] w_alu;
  logic                w_c;
  logic                w_v;
  logic                w_pass;

  // Subtraction reuses the adder: a + ~b + 1.
  always_comb begin
    w_b_eff = (r_op == OP_SUB) ? ~r_b : r_b;
    w_sum   = {1'b0, r_a} + {1'b0, w_b_eff} + {{ULA_BITS{1'b0}}, (r_op == OP_SUB)};
    w_alu   = w_sum[ULA_BITS-1:0];
    w_c     = 1'b0;
    w_v     = 1'b0;
    if ((r_op == OP_ADD) || (r_op == OP_SUB)) begin
      w_c = w_sum[ULA_BITS];
      w_v = (r_a[ULA_BITS-1] == w_b_eff[ULA_BITS-1]) &&
            (w_sum[ULA_BITS-1] != r_a[ULA_BITS-1]);
    end else if (r_op == OP_AND) begin
      w_alu = r_a & r_b;
    end else begin
      w_alu = r_a | r_b;
    end
  end

`ifdef ULA_EXEC_COND_EN
  logic [2:0] r_cond;

  // Condition is tested against the flags held before this operation commits.
  always_comb begin
    w_pass = 1'b1;
    case (r_cond)
      3'b000:  w_pass = 1'b1;
      3'b001:  w_pass = r_z;
      3'b010:  w_pass = ~r_z;
      3'b011:  w_pass = r_c;
      3'b100:  w_pass = ~r_c;
      3'b101:  w_pass = r_c & ~r_z;
      3'b110:  w_pass = ~r_c | r_z;
      default: w_pass = r_n;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cond <= 3'b000;
    end else if ((r_state == S_IDLE) && in_valid) begin
      r_cond <= cond;
    end
  end
`else
  logic w_unused_cond;

  assign w_unused_cond = ^cond;
  assign w_pass        = 1'b1;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_a        <= '0;
      r_b        <= '0;
      r_op       <= 2'b00;
      r_result   <= '0;
      r_z        <= 1'b0;
      r_c        <= 1'b0;
      r_v        <= 1'b0;
      r_n        <= 1'b0;
      r_executed <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_a     <= a;
            r_b     <= b;
            r_op    <= ALUControl;
            r_state <= S_EXEC;
          end
        end
        S_EXEC: begin
          r_state    <= S_DONE;
          r_executed <= w_pass;
          if (w_pass) begin
            r_result <= w_alu;
            r_z      <= (w_alu == '0);
            r_c      <= w_c;
            r_v      <= w_v;
            r_n      <= w_alu[ULA_BITS-1];
          end
        end
        S_DONE: begin
          if (out_ready) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
      // Clear overrides a coincident commit; the result itself still commits.
      if (flags_clr) begin
        r_z <= 1'b0;
        r_c <= 1'b0;
        r_v <= 1'b0;
        r_n <= 1'b0;
      end
    end
  end

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign result    = r_result;
  assign zero      = r_z;
  assign carry     = r_c;
  assign overflow  = r_v;
  assign negative  = r_n;
  assign executed  = r_executed;

endmodule
